// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes a parallel word LSB-first as start, data, optional parity, stop.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (adds PAR_EN/PAR_TYP ports).
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
`ifdef UART_TX_PARITY_EN
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`endif
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int PW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t                  state_reg;
    logic [PW-1:0]           pre_cnt_reg;
    logic [BW-1:0]           bit_cnt_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    tx_reg;
    logic                    busy_reg;
    logic [DATA_WIDTH-1:0]   shift_next;
`ifdef UART_TX_PARITY_EN
    logic                    par_en_reg;
    logic                    par_bit_reg;
`endif

    assign shift_next = shift_reg >> 1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            pre_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg      <= 1'b1;
                    busy_reg    <= 1'b0;
                    pre_cnt_reg <= '0;
                    bit_cnt_reg <= '0;
                    if (DATA_VALID) begin
                        shift_reg <= P_DATA;
                        state_reg <= START;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        // Parity is taken from the word as accepted, so later P_DATA changes cannot affect it.
                        par_en_reg  <= PAR_EN;
                        par_bit_reg <= (^P_DATA) ^ PAR_TYP;
`endif
                    end
                end
                default: begin
                    if (pre_cnt_reg != PRE_LAST) begin
                        pre_cnt_reg <= pre_cnt_reg + 1'b1;
                    end else begin
                        pre_cnt_reg <= '0;
                        case (state_reg)
                            START: begin
                                state_reg   <= DATA;
                                tx_reg      <= shift_reg[0];
                                bit_cnt_reg <= '0;
                            end
                            DATA: begin
                                if (bit_cnt_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                                    if (par_en_reg) begin
                                        state_reg <= PARITY;
                                        tx_reg    <= par_bit_reg;
                                    end else begin
                                        state_reg <= STOP;
                                        tx_reg    <= 1'b1;
                                    end
`else
                                    state_reg <= STOP;
                                    tx_reg    <= 1'b1;
`endif
                                end else begin
                                    shift_reg   <= shift_next;
                                    tx_reg      <= shift_next[0];
                                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                end
                            end
`ifdef UART_TX_PARITY_EN
                            PARITY: begin
                                state_reg <= STOP;
                                tx_reg    <= 1'b1;
                            end
`endif
                            default: begin
                                // End of stop bit: the idle cycle that follows guarantees the inter-frame gap.
                                state_reg <= IDLE;
                                tx_reg    <= 1'b1;
                                busy_reg  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign TX_OUT = tx_reg;
    assign BUSY   = busy_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: default instance (PRESCALE=8) and a PRESCALE=4 instance.
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] p_data0, p_data1;
    logic       dv0, dv1;
    logic       tx0, tx1;
    logic       busy0, busy1;
    logic       par_en, par_typ;
    int         n_checks;
    int         n_fails;

    uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE(8)) dut0 (
        .CLK        (clk),
        .RST        (rst),
`ifdef UART_TX_PARITY_EN
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
`endif
        .P_DATA     (p_data0),
        .DATA_VALID (dv0),
        .TX_OUT     (tx0),
        .BUSY       (busy0)
    );

    uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE(4)) dut1 (
        .CLK        (clk),
        .RST        (rst),
`ifdef UART_TX_PARITY_EN
        .PAR_EN     (1'b0),
        .PAR_TYP    (1'b0),
`endif
        .P_DATA     (p_data1),
        .DATA_VALID (dv1),
        .TX_OUT     (tx1),
        .BUSY       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int dut, input logic dv, input logic [7:0] d);
        if (dut == 0) begin
            dv0 = dv;
            p_data0 = d;
        end else begin
            dv1 = dv;
            p_data1 = d;
        end
    endtask

    function automatic logic get_tx(input int dut);
        return (dut == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_busy(input int dut);
        return (dut == 0) ? busy0 : busy1;
    endfunction

    // Called on the first cycle of the start bit; returns on the first idle cycle after the stop bit.
    task automatic check_frame(input string name, input int dut, input logic [7:0] data,
                               input bit par, input bit par_odd, input logic dv_after,
                               input logic [7:0] pd_after, input int inj_cycle,
                               input logic [7:0] inj_data);
        int   pre;
        int   nbits;
        int   cyc;
        int   busy_cnt;
        int   cnt;
        logic exp;
        pre      = (dut == 0) ? 8 : 4;
        nbits    = par ? 11 : 10;
        cyc      = 0;
        busy_cnt = 0;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)
                exp = 1'b0;
            else if (b <= 8)
                exp = data[b-1];
            else if (par && b == 9)
                exp = (^data) ^ par_odd;
            else
                exp = 1'b1;
            cnt = 0;
            for (int j = 0; j < pre; j++) begin
                if (cyc == 0)
                    drive(dut, dv_after, pd_after);
                if (cyc == inj_cycle)
                    drive(dut, 1'b1, inj_data);
                else if (cyc == inj_cycle + 1)
                    drive(dut, dv_after, pd_after);
                if (get_tx(dut) === exp) cnt++;
                if (get_busy(dut) === 1'b1) busy_cnt++;
                cyc++;
                tick();
            end
            n_checks++;
            if (cnt !== pre) begin
                n_fails++;
                $display("FAIL %s bit%0d: %0d cycles at level %b, required %0d", name, b, cnt, exp, pre);
            end
        end
        n_checks++;
        if (busy_cnt !== nbits * pre) begin
            n_fails++;
            $display("FAIL %s busy_len: busy %0d cycles, required %0d", name, busy_cnt, nbits * pre);
        end
        n_checks++;
        if (get_tx(dut) !== 1'b1) begin
            n_fails++;
            $display("FAIL %s idle_tx: tx=%b, required 1", name, get_tx(dut));
        end
        n_checks++;
        if (get_busy(dut) !== 1'b0) begin
            n_fails++;
            $display("FAIL %s idle_busy: busy=%b, required 0", name, get_busy(dut));
        end
        $display("frame %s data=0x%02h checked (%0d bits x %0d cycles)", name, data, nbits, pre);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_dut0: tx=%b busy=%b, required tx=1 busy=0", tx0, busy0);
        end
        n_checks++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_dut1: tx=%b busy=%b, required tx=1 busy=0", tx1, busy1);
        end
        rst = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset_idle: tx=%b busy=%b, required tx=1 busy=0", tx0, busy0);
        end
        $display("reset checked");
    endtask

    task automatic test_basic;
        drive(0, 1'b1, 8'hA5);
        tick();
        check_frame("basic_a5", 0, 8'hA5, 0, 0, 1'b0, 8'h00, -1, 8'h00);
    endtask

    task automatic test_busy_reject;
        int idle_cnt;
        drive(0, 1'b1, 8'h3C);
        tick();
        check_frame("reject_3c", 0, 8'h3C, 0, 0, 1'b0, 8'h3C, 20, 8'hFF);
        idle_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (tx0 === 1'b1 && busy0 === 1'b0) idle_cnt++;
            tick();
        end
        n_checks++;
        if (idle_cnt !== 20) begin
            n_fails++;
            $display("FAIL reject_after: idle %0d of 20 cycles, required 20", idle_cnt);
        end
        $display("busy rejection checked");
    endtask

    task automatic test_back_to_back;
        drive(0, 1'b1, 8'h00);
        tick();
        check_frame("b2b_00", 0, 8'h00, 0, 0, 1'b1, 8'h81, -1, 8'h00);
        tick();
        check_frame("b2b_81", 0, 8'h81, 0, 0, 1'b0, 8'h00, -1, 8'h00);
    endtask

    task automatic test_reset_midframe;
        int idle_cnt;
        drive(0, 1'b1, 8'h55);
        tick();
        drive(0, 1'b0, 8'h55);
        repeat (35) tick();
        n_checks++;
        if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
            n_fails++;
            $display("FAIL midframe_bit3: tx=%b busy=%b, required tx=0 busy=1", tx0, busy0);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fails++;
            $display("FAIL async_reset: tx=%b busy=%b, required tx=1 busy=0", tx0, busy0);
        end
        repeat (2) tick();
        rst = 1'b1;
        idle_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (tx0 === 1'b1 && busy0 === 1'b0) idle_cnt++;
            tick();
        end
        n_checks++;
        if (idle_cnt !== 16) begin
            n_fails++;
            $display("FAIL reset_release_idle: idle %0d of 16 cycles, required 16", idle_cnt);
        end
        drive(0, 1'b1, 8'h55);
        tick();
        check_frame("after_reset_55", 0, 8'h55, 0, 0, 1'b0, 8'h00, -1, 8'h00);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        par_en  = 1'b1;
        par_typ = 1'b0;
        drive(0, 1'b1, 8'hA5);
        tick();
        par_typ = 1'b1;
        check_frame("parity_even", 0, 8'hA5, 1, 0, 1'b0, 8'h00, -1, 8'h00);
        tick();
        par_typ = 1'b1;
        drive(0, 1'b1, 8'hA5);
        tick();
        par_typ = 1'b0;
        check_frame("parity_odd", 0, 8'hA5, 1, 1, 1'b0, 8'h00, -1, 8'h00);
        par_en = 1'b0;
    endtask
`endif

    task automatic test_prescale4;
        drive(1, 1'b1, 8'h01);
        tick();
        check_frame("pre4_01", 1, 8'h01, 0, 0, 1'b0, 8'h00, -1, 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b0;
        dv0      = 1'b0;
        dv1      = 1'b0;
        p_data0  = 8'h00;
        p_data1  = 8'h00;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        test_reset();
        test_basic();
        tick();
        test_busy_reject();
        test_back_to_back();
        tick();
        test_reset_midframe();
        tick();
`ifdef UART_TX_PARITY_EN
        test_parity();
        tick();
`endif
        test_prescale4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmitter; the transmit-side counterpart of the team's 8x-oversampled UART receiver path.
- Accepts a parallel word over a valid/busy handshake and serializes it LSB-first as start, data, optional parity and stop.
- Each bit is held for PRESCALE cycles of the oversampling clock CLK, so one bit time matches the receiver's 8-edge bit window.
- Sits between the host-side register/FIFO logic and the TX pad.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (1..16).
- PRESCALE, 8, CLK cycles per bit (>=2); 8 matches the receiver's 3-bit edge counter.

Ports:
- CLK  input  1  oversampling clock (PRESCALE x baud).
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word; sampled only on acceptance.
- DATA_VALID  input  1  request to send P_DATA.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  high while a frame is in progress.
- PAR_EN  input  1  (only with UART_TX_PARITY_EN) insert parity bit.
- PAR_TYP  input  1  (only with UART_TX_PARITY_EN) 0 = even, 1 = odd.

Behaviour:
- Reset (RST low, asynchronous): TX_OUT = 1, BUSY = 0, FSM = IDLE, bit counter = 0, prescale counter = 0, shift register = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: TX_OUT = 1, BUSY = 0.
  - DATA_VALID high at a CLK edge: latch P_DATA; latch PAR_EN/PAR_TYP if present.
  - Next cycle: FSM = START, TX_OUT = 0, BUSY = 1. Latency from the accepting edge to the start bit is 1 cycle.
- Prescale counter counts 0..PRESCALE-1 in every non-IDLE state. Each bit is driven for exactly PRESCALE cycles. The state advances when the counter reaches PRESCALE-1, and the counter then wraps to 0.
- START: drives 0 for one bit time, then goes to DATA with bit index 0.
- DATA: drives shift[0] and shifts right at each bit boundary. After bit DATA_WIDTH-1, goes to PARITY if parity is enabled, else to STOP.
- PARITY: drives ^latched_data for even parity, or ~^latched_data for odd. Parity is computed from the latched word, not from live P_DATA. Then goes to STOP.
- STOP: drives 1 for one bit time, then returns to IDLE. BUSY falls on the IDLE entry cycle.
- Frame length: (DATA_WIDTH+2, or +3 with parity) x PRESCALE cycles.
- Frames always have at least 1 idle-high cycle between them. Minimum start-to-start spacing is frame length + 1.
- DATA_VALID while BUSY = 1: ignored. No queuing, no effect on the frame in flight.
- P_DATA changing mid-frame: no effect.
- DATA_VALID held continuously: a new frame is accepted on each IDLE cycle, giving back-to-back frames with a 1-cycle gap.
- Reset mid-frame: line immediately returns high, frame aborted, no resumption after reset release.
- PAR_EN/PAR_TYP changes mid-frame: ignored; the latched values apply.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PAR_EN and PAR_TYP ports exist and the PARITY state is reachable. A frame with PAR_EN = 1 is DATA_WIDTH+3 bits.
- Undefined: the ports are absent, the PARITY state is not implemented, and every frame is DATA_WIDTH+2 bits (8N1 at defaults).

Test Plan:
- Defaults, no parity. Pulse DATA_VALID with P_DATA = 0xA5.
  - Required: TX_OUT, per 8-cycle bit, = 0, 1,0,1,0,0,1,0,1, 1.
  - BUSY high for exactly 80 cycles, starting 1 cycle after the accepting edge.
- Parity macro on, 0xA5:
  - PAR_EN = 1, PAR_TYP = 0: parity bit 0.
  - PAR_TYP = 1: parity bit 1.
  - Frame = 88 cycles in both cases.
- Busy rejection. Send 0x3C, then at cycle 20 pulse DATA_VALID with P_DATA = 0xFF.
  - Required: only the 0x3C frame appears; the line stays high afterwards; BUSY stays low after the frame.
- Back-to-back. Hold DATA_VALID high with P_DATA = 0x00 then 0x81.
  - Required: two complete frames with exactly 1 idle-high cycle between the stop bit and the next start bit.
- Reset mid-frame. Assert RST low during data bit 3 of 0x55.
  - Required: TX_OUT = 1 and BUSY = 0 asynchronously.
  - After release: line stays idle until a new DATA_VALID, and the next frame is complete and correct.
- PRESCALE = 4, P_DATA = 0x01.
  - Required: every bit lasts 4 cycles; total 40 cycles; the first data bit is 1.
